// File: rtl/seq_counter.sv
// T-state sequence counter for the CPU control path: steps the 3-bit T index
// through RUN, holds it across memory WAIT stalls, and halts at instruction boundaries.
module seq_counter #(
  parameter int CNT_W    = 3,
  parameter int LAST_T   = 7,
  parameter int WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_req,
  input  logic             sc_clr,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic [CNT_W-1:0] sc,
  output logic             running,
  output logic             stalled,
  output logic             timeout
);

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0]  LAST_SC  = CNT_W'(LAST_T);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);

  typedef enum logic [1:0] {
    S_HALTED = 2'd0,
    S_RUN    = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  sc_q, sc_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              halt_pend_q, halt_pend_d;
  logic              timeout_q, timeout_d;
  logic              running_q, stalled_q;

  logic              at_wrap;
  logic              halt_now;
  logic [CNT_W-1:0]  sc_inc;

  // Explicit wrap compare keeps sc inside 0..LAST_T even when LAST_T < 2**CNT_W-1.
  assign at_wrap  = (sc_q == LAST_SC);
  assign sc_inc   = at_wrap ? '0 : sc_q + CNT_W'(1);
  assign halt_now = halt_pend_q | halt_req;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    sc_d        = sc_q;
    wait_cnt_d  = wait_cnt_q;
    halt_pend_d = halt_pend_q;
    timeout_d   = timeout_q;

    unique case (state_q)
      S_HALTED: begin
        sc_d       = '0;
        wait_cnt_d = '0;
        if (start) begin
          state_d     = S_RUN;
          timeout_d   = 1'b0;
          halt_pend_d = 1'b0;
        end
      end

      S_RUN: begin
        if (sc_clr) begin
          sc_d = '0;
          if (halt_now) begin
            state_d     = S_HALTED;
            halt_pend_d = 1'b0;
          end
        end else if (mem_req && !mem_ready) begin
          state_d     = S_WAIT;
          wait_cnt_d  = WAIT_W'(1);
          halt_pend_d = halt_now;
        end else begin
          sc_d = sc_inc;
          if (at_wrap && halt_now) begin
            state_d     = S_HALTED;
            halt_pend_d = 1'b0;
          end else begin
            halt_pend_d = halt_now;
          end
        end
      end

      S_WAIT: begin
        if (sc_clr) begin
          sc_d       = '0;
          wait_cnt_d = '0;
          if (halt_now) begin
            state_d     = S_HALTED;
            halt_pend_d = 1'b0;
          end else begin
            state_d = S_RUN;
          end
        end else if (mem_ready) begin
          // Transfer completes this cycle: advance immediately, no bubble.
          sc_d       = sc_inc;
          wait_cnt_d = '0;
          if (at_wrap && halt_now) begin
            state_d     = S_HALTED;
            halt_pend_d = 1'b0;
          end else begin
            state_d     = S_RUN;
            halt_pend_d = halt_now;
          end
        end else if (wait_cnt_q == WAIT_LIM) begin
          state_d     = S_HALTED;
          sc_d        = '0;
          wait_cnt_d  = '0;
          timeout_d   = 1'b1;
          halt_pend_d = 1'b0;
        end else begin
          wait_cnt_d  = wait_cnt_q + WAIT_W'(1);
          halt_pend_d = halt_now;
        end
      end

      default: begin
        state_d     = S_HALTED;
        sc_d        = '0;
        wait_cnt_d  = '0;
        halt_pend_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_HALTED;
      sc_q        <= '0;
      wait_cnt_q  <= '0;
      halt_pend_q <= 1'b0;
      timeout_q   <= 1'b0;
      running_q   <= 1'b0;
      stalled_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      sc_q        <= sc_d;
      wait_cnt_q  <= wait_cnt_d;
      halt_pend_q <= halt_pend_d;
      timeout_q   <= timeout_d;
      running_q   <= (state_d != S_HALTED);
      stalled_q   <= (state_d == S_WAIT);
    end
  end

  assign sc      = sc_q;
  assign running = running_q;
  assign stalled = stalled_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_seq_counter.sv
// Directed bench for seq_counter: a per-cycle behavioural model checked every
// cycle, plus hand-computed literal expectations along the directed scenarios.
module tb_seq_counter;

  localparam int CNT_W    = 3;
  localparam int LAST_T   = 7;
  localparam int WAIT_MAX = 15;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             start     = 1'b0;
  logic             halt_req  = 1'b0;
  logic             sc_clr    = 1'b0;
  logic             mem_req   = 1'b0;
  logic             mem_ready = 1'b0;
  logic [CNT_W-1:0] sc;
  logic             running;
  logic             stalled;
  logic             timeout;

  int cmp_total = 0;
  int cmp_fail  = 0;

  seq_counter #(.CNT_W(CNT_W), .LAST_T(LAST_T), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .sc_clr(sc_clr), .mem_req(mem_req), .mem_ready(mem_ready),
    .sc(sc), .running(running), .stalled(stalled), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Model view: is the machine on, is it stalled, which T-state, how long waited.
  typedef struct {
    bit on;
    bit stall;
    int t;
    int waited;
    bit pend;
    bit tmo;
  } model_t;

  model_t m;

  function automatic model_t model_next(input model_t c, input bit st, input bit hr,
                                        input bit clr, input bit rq, input bit rdy);
    model_t n = c;
    bit want_halt = c.pend || hr;
    if (!c.on) begin
      n.t = 0;
      if (st) begin
        n.on = 1; n.tmo = 0; n.pend = 0;
      end
      return n;
    end
    if (clr) begin
      n.t = 0; n.stall = 0; n.waited = 0;
      if (want_halt) begin
        n.on = 0; n.pend = 0;
      end
      return n;
    end
    if (c.stall && !rdy) begin
      if (c.waited == WAIT_MAX) begin
        n.on = 0; n.stall = 0; n.t = 0; n.waited = 0; n.pend = 0; n.tmo = 1;
      end else begin
        n.waited = c.waited + 1; n.pend = want_halt;
      end
      return n;
    end
    if (!c.stall && rq && !rdy) begin
      n.stall = 1; n.waited = 1; n.pend = want_halt;
      return n;
    end
    n.stall  = 0;
    n.waited = 0;
    n.t      = (c.t + 1) % (LAST_T + 1);
    if (n.t == 0 && want_halt) begin
      n.on = 0; n.pend = 0;
    end else begin
      n.pend = want_halt;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{default: 0};
    else        m <= model_next(m, start, halt_req, sc_clr, mem_req, mem_ready);
  end

  task automatic check(input string name, input int act, input int exp);
    cmp_total++;
    if (act !== exp) begin
      cmp_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_sc",      int'(sc),      m.t);
    check("model_running", int'(running), int'(m.on));
    check("model_stalled", int'(stalled), int'(m.stall));
    check("model_timeout", int'(timeout), int'(m.tmo));
  end

  // Apply one cycle of inputs, then let outputs settle just after the edge.
  task automatic cyc(input bit st, input bit hr, input bit clr, input bit rq, input bit rdy);
    start = st; halt_req = hr; sc_clr = clr; mem_req = rq; mem_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_sc",      int'(sc),      0);
    check("reset_running", int'(running), 0);
    check("reset_timeout", int'(timeout), 0);
    rst_n = 1'b1;
    idle(1);
    check("halted_idle_sc", int'(sc), 0);

    // 1: start, then count 0..7 and wrap
    cyc(1, 0, 0, 0, 0);
    check("t1_first_sc", int'(sc), 0);
    check("t1_running",  int'(running), 1);
    for (int i = 1; i <= 9; i++) begin
      idle(1);
      check("t1_seq_sc", int'(sc), i % 8);
    end
    check("t1_still_running", int'(running), 1);

    // 2: sc_clr at sc=3, then sc_clr+halt_req at sc=5
    idle(2);
    check("t2_at3", int'(sc), 3);
    cyc(0, 0, 1, 0, 0);
    check("t2_clr_sc", int'(sc), 0);
    check("t2_clr_running", int'(running), 1);
    idle(5);
    check("t2_at5", int'(sc), 5);
    cyc(0, 1, 1, 0, 0);
    check("t2_halt_sc", int'(sc), 0);
    check("t2_halt_running", int'(running), 0);
    idle(1);
    check("t2_halted_stays", int'(running), 0);
    cyc(1, 0, 0, 0, 0);
    check("t2_restart_sc", int'(sc), 0);
    idle(1);
    check("t2_restart_sc1", int'(sc), 1);

    // 3: three stalled cycles at sc=2
    idle(1);
    check("t3_at2", int'(sc), 2);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 0);
      check("t3_stall_sc", int'(sc), 2);
      check("t3_stalled",  int'(stalled), 1);
    end
    cyc(0, 0, 0, 1, 1);
    check("t3_done_sc", int'(sc), 3);
    check("t3_done_stalled", int'(stalled), 0);

    // 4: memory never ready -> timeout after 15 wait cycles
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < WAIT_MAX - 1; i++) cyc(0, 0, 0, 1, 0);
    check("t4_last_wait_stalled", int'(stalled), 1);
    check("t4_no_timeout_yet",    int'(timeout), 0);
    cyc(0, 0, 0, 1, 0);
    check("t4_timeout",  int'(timeout), 1);
    check("t4_halted",   int'(running), 0);
    check("t4_sc",       int'(sc), 0);
    idle(1);
    check("t4_sticky", int'(timeout), 1);
    cyc(1, 0, 0, 0, 0);
    check("t4_cleared", int'(timeout), 0);
    check("t4_rerun",   int'(running), 1);

    // 5: halt_req mid-instruction halts at wrap; halt_req during WAIT
    idle(4);
    check("t5_at4", int'(sc), 4);
    cyc(0, 1, 0, 0, 0);
    check("t5_at5", int'(sc), 5);
    idle(2);
    check("t5_at7_running", int'(running), 1);
    idle(1);
    check("t5_wrap_sc", int'(sc), 0);
    check("t5_wrap_halted", int'(running), 0);
    cyc(1, 0, 0, 0, 0);
    idle(2);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 1, 0);
    check("t5_wait_halt_stalled", int'(stalled), 1);
    cyc(0, 0, 0, 1, 1);
    check("t5_resume_sc", int'(sc), 3);
    idle(4);
    check("t5_at7", int'(sc), 7);
    check("t5_at7_run", int'(running), 1);
    idle(1);
    check("t5_boundary_halted", int'(running), 0);

    // 6: async reset mid-WAIT at sc=6
    cyc(1, 0, 0, 0, 0);
    idle(6);
    cyc(0, 0, 0, 1, 0);
    check("t6_wait_sc", int'(sc), 6);
    check("t6_wait_stalled", int'(stalled), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_sc",      int'(sc),      0);
    check("t6_rst_running", int'(running), 0);
    check("t6_rst_stalled", int'(stalled), 0);
    check("t6_rst_timeout", int'(timeout), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mem_req = 1'b0;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_total, cmp_fail);
    $finish;
  end

endmodule
